// File: rtl/rat_pkg.sv
// Shared types and constants for the rational-arithmetic datapath.
// The types here are the default-width view of a rational value and of
// one multiplier pipeline entry; width-generic blocks declare local
// equivalents sized by their own WIDTH parameter.
package rat_pkg;

    localparam int RAT_WIDTH = 32;

    typedef logic [RAT_WIDTH-1:0]   rat_word_t;
    typedef logic [2*RAT_WIDTH-1:0] rat_wide_t;

    // A rational value num/den, both unsigned.
    typedef struct packed {
        rat_word_t num;
        rat_word_t den;
    } rat_t;

    // One multiplier pipeline entry: full products plus their flags.
    typedef struct packed {
        rat_wide_t pn;
        rat_wide_t pd;
        logic      ovf;
        logic      dz;
    } rat_entry_t;

    // Saturation value for a component whose product overflowed.
    localparam rat_word_t RAT_MAX = '1;

endpackage

// File: rtl/rat_mul_core.sv
// Combinational core of the rational multiplier: full-width products of
// numerators and denominators, plus overflow and zero-denominator flags.
module rat_mul_core
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic [WIDTH-1:0]   l_num,
    input  logic [WIDTH-1:0]   l_den,
    input  logic [WIDTH-1:0]   r_num,
    input  logic [WIDTH-1:0]   r_den,
    output logic [2*WIDTH-1:0] pn,
    output logic [2*WIDTH-1:0] pd,
    output logic               ovf,
    output logic               dz
);

    // Zero-extend before multiplying so the full 2*WIDTH product is kept.
    always_comb begin
        pn  = {{WIDTH{1'b0}}, l_num} * {{WIDTH{1'b0}}, r_num};
        pd  = {{WIDTH{1'b0}}, l_den} * {{WIDTH{1'b0}}, r_den};
        ovf = (|pn[2*WIDTH-1:WIDTH]) || (|pd[2*WIDTH-1:WIDTH]);
        dz  = (l_den == '0) || (r_den == '0);
    end

endmodule

// File: rtl/rat_mul_pipe.sv
// Pipelined rational multiplier: (l_num/l_den)*(r_num/r_den).
// Stage 1 captures the full products and flags; later stages shift them.
// All stages advance together under one enable derived from the output
// handshake.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = !out_valid || out_ready (combinational from out_ready);
// out_valid and the data it qualifies hold stable while out_ready is low.
//
// Build option RAT_MUL_SAT_EN: when defined, a result component whose
// product exceeds WIDTH bits saturates to all ones; otherwise it wraps.
module rat_mul_pipe
    import rat_pkg::*;
#(
    parameter int WIDTH  = RAT_WIDTH,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den,
    output logic             ovf,
    output logic             dz
);

    typedef struct packed {
        logic [2*WIDTH-1:0] pn;
        logic [2*WIDTH-1:0] pd;
        logic               ovf;
        logic               dz;
    } entry_t;

    logic [2*WIDTH-1:0] core_pn;
    logic [2*WIDTH-1:0] core_pd;
    logic               core_ovf;
    logic               core_dz;
    entry_t             cap_d;
    entry_t             last;
    logic               en;

    entry_t stage_q [STAGES];
    logic   valid_q [STAGES];

    rat_mul_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .l_num (l_num),
        .l_den (l_den),
        .r_num (r_num),
        .r_den (r_den),
        .pn    (core_pn),
        .pd    (core_pd),
        .ovf   (core_ovf),
        .dz    (core_dz)
    );

    // Bundle the core outputs into the entry captured by stage 1.
    always_comb begin
        cap_d = {core_pn, core_pd, core_ovf, core_dz};
    end

    // Global stall: the whole pipe moves only when the output slot can empty.
    always_comb begin
        en       = !valid_q[STAGES-1] || out_ready;
        in_ready = en;
    end

    // Pipeline registers; reset discards every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                stage_q[i] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= in_valid;
            stage_q[0] <= cap_d;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Output view of the final stage; flags never leak from a bubble.
    always_comb begin
        last      = stage_q[STAGES-1];
        out_valid = valid_q[STAGES-1];
        ovf       = last.ovf && valid_q[STAGES-1];
        dz        = last.dz  && valid_q[STAGES-1];
    end

`ifdef RAT_MUL_SAT_EN
    // Each component saturates independently when its upper half is set.
    always_comb begin
        s_num = (|last.pn[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}} : last.pn[WIDTH-1:0];
        s_den = (|last.pd[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}} : last.pd[WIDTH-1:0];
    end
`else
    logic unused_hi;

    // Components wrap to their low WIDTH bits; the upper halves only fed ovf.
    always_comb begin
        s_num     = last.pn[WIDTH-1:0];
        s_den     = last.pd[WIDTH-1:0];
        unused_hi = ^{last.pn[2*WIDTH-1:WIDTH], last.pd[2*WIDTH-1:WIDTH]};
    end
`endif

endmodule

// File: tb/tb_rat_mul_pipe.sv
// Bench for rat_mul_pipe at WIDTH=8, STAGES=3. A reference model computes
// each result from plain integer arithmetic when an operand set is
// accepted; a compare process checks every output transfer, the ready
// rule, flag masking and stall stability. Directed cases pin the model
// with hand-computed literals. Honours RAT_MUL_SAT_EN like the design.
module tb_rat_mul_pipe;

    localparam int W    = 8;
    localparam int S    = 3;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] l_num, l_den, r_num, r_den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_num, s_den;
    logic         ovf, dz;

    int checks = 0;
    int errors = 0;
    int out_count = 0;
    int last_out_num = -1;
    logic bp_done;

    // Expected results, packed as {ovf, dz, num, den}.
    logic [2*W+1:0] exp_q[$];

    logic         hold_v;
    logic [W-1:0] hold_num, hold_den;
    logic         hold_ovf, hold_dz;

    rat_mul_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .l_num     (l_num),
        .l_den     (l_den),
        .r_num     (r_num),
        .r_den     (r_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_num     (s_num),
        .s_den     (s_den),
        .ovf       (ovf),
        .dz        (dz)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result of the rational product as the block must present it.
    function automatic logic [2*W+1:0] model(input int ln, input int ld, input int rn, input int rd);
        int pn;
        int pd;
        logic o;
        logic z;
        logic [W-1:0] n;
        logic [W-1:0] d;
        pn = ln * rn;
        pd = ld * rd;
        o  = (pn > MAXV) || (pd > MAXV);
        z  = (ld == 0) || (rd == 0);
`ifdef RAT_MUL_SAT_EN
        n = (pn > MAXV) ? W'(MAXV) : W'(pn % (MAXV + 1));
        d = (pd > MAXV) ? W'(MAXV) : W'(pd % (MAXV + 1));
`else
        n = W'(pn % (MAXV + 1));
        d = W'(pd % (MAXV + 1));
`endif
        return {o, z, n, d};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [2*W+1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            hold_v = 1'b0;
            check("reset_out_valid", out_valid, 0);
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (!out_valid) begin
                check("bubble_flags", {ovf, dz}, 0);
            end
            if (hold_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", {ovf, dz, s_num, s_den}, {hold_ovf, hold_dz, hold_num, hold_den});
            end
            if (out_valid && !out_ready) begin
                hold_v   = 1'b1;
                hold_num = s_num;
                hold_den = s_den;
                hold_ovf = ovf;
                hold_dz  = dz;
            end else begin
                hold_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                out_count++;
                last_out_num = int'(s_num);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d/%0d expected no output", s_num, s_den);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {ovf, dz, s_num, s_den}, e);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(l_num), int'(l_den), int'(r_num), int'(r_den)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call in the phase just after a rising edge; returns just after the
    // edge on which the operand set was accepted.
    task automatic send(input int ln, input int ld, input int rn, input int rd);
        int waited;
        waited   = 0;
        l_num    = W'(ln);
        l_den    = W'(ld);
        r_num    = W'(rn);
        r_den    = W'(rd);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Call right after send with an empty pipe and out_ready=1; checks the
    // first result against literals and counts edges from the accept edge.
    task automatic wait_out(input string name, input int en, input int ed, input int eo, input int ez);
        int edges;
        int t;
        edges = 1;
        t     = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got out_valid=0 expected out_valid=1 within 20 cycles", name);
        end else begin
            check({name, "_latency"}, edges, S);
            check({name, "_num"}, s_num, en);
            check({name, "_den"}, s_den, ed);
            check({name, "_ovf"}, ovf, eo);
            check({name, "_dz"}, dz, ez);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        bp_done   = 1'b0;
        hold_v    = 1'b0;
        l_num = 8'd3; l_den = 8'd4; r_num = 8'd5; r_den = 8'd7;

        // Reset held with in_valid=1; nothing may be captured.
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s_num", s_num, 0);
        check("rst_s_den", s_den, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dz", dz, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Literal cases.
        send(3, 4, 5, 7);
        wait_out("basic", 15, 28, 0, 0);
        send(20, 3, 15, 2);
`ifdef RAT_MUL_SAT_EN
        wait_out("overflow", 255, 6, 1, 0);
`else
        wait_out("overflow", 44, 6, 1, 0);
`endif
        send(1, 0, 2, 9);
        wait_out("zero_den", 2, 0, 0, 1);
        send(0, 0, 0, 0);
        wait_out("zero_zero", 0, 0, 0, 1);
        send(255, 255, 255, 1);
`ifdef RAT_MUL_SAT_EN
        wait_out("max", 255, 255, 1, 0);
`else
        wait_out("max", 1, 255, 1, 0);
`endif

        // Back-pressure: out_ready follows 1,0,0,1,0,0,...
        base = out_count;
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    send(i, 1, 2, 1);
                end
                drain("bp");
                bp_done = 1'b1;
            end
            begin
                int c;
                c = 0;
                while (!bp_done) begin
                    out_ready = (c % 3 == 0);
                    c++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        check("bp_count", out_count - base, 10);
        check("bp_last", last_out_num, 20);

        // Mid-flight reset: three accepted operands must never emerge.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        base = out_count;
        send(9, 1, 9, 1);
        send(8, 1, 8, 1);
        send(7, 1, 7, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        send(6, 1, 7, 1);
        wait_out("after_rst", 42, 1, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("after_rst_count", out_count - base, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
